// File: rtl/lz_pkg.sv
// Symbol map and state encoding shared by the inflate front end and lz_extractor.
package lz_pkg;

  localparam logic [4:0] SYM_EOB       = 5'd16;
  localparam logic [4:0] SYM_LEN_BASE  = 5'd17;
  localparam logic [4:0] SYM_DIST_BASE = 5'd25;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    EOB_WAIT
  } lz_state_e;

  // Length codes share extra-bit counts in pairs; distance codes step by one.
  function automatic logic [2:0] ext_len(input logic [4:0] sym);
    if (sym >= SYM_DIST_BASE) begin
      return 3'(sym - SYM_DIST_BASE);
    end else if (sym >= SYM_LEN_BASE) begin
      return 3'((sym - SYM_LEN_BASE) >> 1);
    end else begin
      return 3'd0;
    end
  endfunction

endpackage

// File: rtl/lz_sym_unpacker.sv
// Unpacks an LSB-first byte stream into 5-bit LZ symbols plus extra bits,
// realigning to a byte boundary after each EOB token.
//   state    | meaning
//   IDLE     | buffer and token slot cleared, waiting for en
//   RUN      | appending bytes and extracting tokens
//   EOB_WAIT | EOB token held in the slot, appends only, until it handshakes
module lz_sym_unpacker
  import lz_pkg::*;
#(
  parameter int BUF_W = 24,
  parameter int CNT_W = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       byte_vld,
  input  logic [7:0] byte_in,
  output logic       byte_rdy,
  output logic       data_in_vld,
  output logic [4:0] data_in,
  output logic [5:0] ext_bits,
  input  logic       data_in_rdy,
  output logic       eob_done
);

  lz_state_e        state_q, state_d;
  logic [BUF_W-1:0] bbuf_q, bbuf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             vld_q, vld_d;
  logic [4:0]       sym_q, sym_d;
  logic [5:0]       ext_q, ext_d;

  logic [4:0]       sym_head;
  logic [2:0]       ext_n;
  logic [5:0]       ext_mask;
  logic [CNT_W-1:0] need, align, consumed, rem;
  logic             slot_free, take_byte, extract, is_eob;

  assign sym_head  = bbuf_q[4:0];
  assign ext_n     = ext_len(sym_head);
  assign ext_mask  = ~(6'h3F << ext_n);
  assign need      = CNT_W'(5) + CNT_W'(ext_n);
  assign is_eob    = (sym_head == SYM_EOB);
  // Bits left in the partially consumed byte once the 5-bit EOB is removed.
  assign align     = (cnt_q - CNT_W'(5)) & CNT_W'(7);

  assign byte_rdy  = en && (state_q != IDLE) && (cnt_q <= CNT_W'(16));
  assign take_byte = byte_vld && byte_rdy;
  assign slot_free = !vld_q || data_in_rdy;
  assign extract   = en && (state_q == RUN) && (cnt_q >= CNT_W'(5)) &&
                     (cnt_q >= need) && slot_free;
  assign consumed  = extract ? (is_eob ? need + align : need) : '0;
  assign rem       = cnt_q - consumed;

  assign data_in_vld = vld_q;
  assign data_in     = sym_q;
  assign ext_bits    = ext_q;
  assign eob_done    = en && (state_q == EOB_WAIT) && vld_q && data_in_rdy;

  always_comb begin
    state_d = state_q;
    bbuf_d  = bbuf_q >> consumed;
    cnt_d   = rem;
    vld_d   = vld_q;
    sym_d   = sym_q;
    ext_d   = ext_q;

    if (take_byte) begin
      bbuf_d = bbuf_d | (BUF_W'(byte_in) << rem);
      cnt_d  = rem + CNT_W'(8);
    end

    if (extract) begin
      vld_d = 1'b1;
      sym_d = sym_head;
      ext_d = bbuf_q[10:5] & ext_mask;
    end else if (data_in_rdy) begin
      vld_d = 1'b0;
    end

    case (state_q)
      IDLE:     state_d = RUN;
      RUN:      if (extract && is_eob) state_d = EOB_WAIT;
      EOB_WAIT: if (vld_q && data_in_rdy) state_d = RUN;
      default:  state_d = IDLE;
    endcase

    if (!en || state_q == IDLE) begin
      bbuf_d = '0;
      cnt_d  = '0;
      vld_d  = 1'b0;
      sym_d  = '0;
      ext_d  = '0;
    end
    if (!en) state_d = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      bbuf_q  <= '0;
      cnt_q   <= '0;
      vld_q   <= 1'b0;
      sym_q   <= '0;
      ext_q   <= '0;
    end else begin
      state_q <= state_d;
      bbuf_q  <= bbuf_d;
      cnt_q   <= cnt_d;
      vld_q   <= vld_d;
      sym_q   <= sym_d;
      ext_q   <= ext_d;
    end
  end

endmodule

// File: tb/tb_lz_sym_unpacker.sv
// Self-checking bench for lz_sym_unpacker: accepted bytes are re-parsed by a
// bit-queue reference model and compared against the handshaked tokens.
module tb_lz_sym_unpacker;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       byte_vld = 1'b0;
  logic [7:0] byte_in = 8'h00;
  logic       data_in_rdy = 1'b0;
  logic       byte_rdy, data_in_vld, eob_done;
  logic [4:0] data_in;
  logic [5:0] ext_bits;

  int vectors = 0;
  int errs = 0;

  logic [7:0] acc_q[$];
  logic [4:0] obs_sym[$];
  logic [5:0] obs_ext[$];
  logic       obs_eob[$];
  int         stray_eob = 0;

  lz_sym_unpacker dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .byte_vld(byte_vld), .byte_in(byte_in), .byte_rdy(byte_rdy),
    .data_in_vld(data_in_vld), .data_in(data_in), .ext_bits(ext_bits),
    .data_in_rdy(data_in_rdy), .eob_done(eob_done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n) begin
      if (byte_vld && byte_rdy) acc_q.push_back(byte_in);
      if (data_in_vld && data_in_rdy) begin
        obs_sym.push_back(data_in);
        obs_ext.push_back(ext_bits);
        obs_eob.push_back(eob_done);
      end else if (eob_done) begin
        stray_eob++;
      end
    end
  end

  // Reference: parse the whole bit stream as a list of bits.
  task automatic model_tokens(input logic [7:0] bytes[$], output logic [4:0] syms[$],
                              output logic [5:0] exts[$]);
    bit bits[$];
    int pos, sym, el, ext;
    syms = {};
    exts = {};
    foreach (bytes[i]) for (int b = 0; b < 8; b++) bits.push_back(bytes[i][b]);
    pos = 0;
    while (bits.size() - pos >= 5) begin
      sym = 0;
      for (int i = 0; i < 5; i++) sym += int'(bits[pos+i]) << i;
      if (sym >= 25) el = sym - 25;
      else if (sym >= 17) el = (sym - 17) / 2;
      else el = 0;
      if (bits.size() - pos < 5 + el) break;
      ext = 0;
      for (int i = 0; i < el; i++) ext += int'(bits[pos+5+i]) << i;
      pos += 5 + el;
      if (sym == 16) pos = ((pos + 7) / 8) * 8;
      syms.push_back(5'(sym));
      exts.push_back(6'(ext));
    end
  endtask

  task automatic do_abort();
    @(posedge clk); #1;
    en = 1'b0; byte_vld = 1'b0; data_in_rdy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    acc_q = {}; obs_sym = {}; obs_ext = {}; obs_eob = {}; stray_eob = 0;
    en = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic drive_stream(input logic [7:0] bytes[$], input int vld_pct, input int rdy_pct,
                              input int exp_n, output bit timed_out);
    int base, idx, cyc;
    base = acc_q.size();
    cyc = 0;
    timed_out = 1'b0;
    forever begin
      idx = acc_q.size() - base;
      if (idx >= bytes.size() && obs_sym.size() >= exp_n) break;
      if (cyc >= 600) begin timed_out = 1'b1; break; end
      if (idx < bytes.size()) begin
        byte_in  = bytes[idx];
        byte_vld = ($urandom_range(99) < vld_pct);
      end else begin
        byte_vld = 1'b0;
      end
      data_in_rdy = ($urandom_range(99) < rdy_pct);
      @(posedge clk); #1;
      cyc++;
    end
    byte_vld = 1'b0;
    data_in_rdy = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    data_in_rdy = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; byte_vld = 1'b1; byte_in = 8'hFF; data_in_rdy = 1'b1;
    #3;
    vectors++; if (byte_rdy !== 1'b0)    begin errs++; $display("FAIL reset_byte_rdy: got %b expected 0", byte_rdy); end
    vectors++; if (data_in_vld !== 1'b0) begin errs++; $display("FAIL reset_vld: got %b expected 0", data_in_vld); end
    vectors++; if (data_in !== 5'd0)     begin errs++; $display("FAIL reset_data_in: got %0d expected 0", data_in); end
    vectors++; if (ext_bits !== 6'd0)    begin errs++; $display("FAIL reset_ext_bits: got %h expected 0", ext_bits); end
    vectors++; if (eob_done !== 1'b0)    begin errs++; $display("FAIL reset_eob_done: got %b expected 0", eob_done); end
    byte_vld = 1'b0; data_in_rdy = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    vectors++; if (byte_rdy !== 1'b0) begin errs++; $display("FAIL idle_byte_rdy: got %b expected 0", byte_rdy); end
    @(posedge clk); #1;
    vectors++; if (byte_rdy !== 1'b1) begin errs++; $display("FAIL run_byte_rdy: got %b expected 1", byte_rdy); end
  endtask

  task automatic test_latency();
    do_abort();
    byte_in = 8'h23; byte_vld = 1'b1; data_in_rdy = 1'b1;
    vectors++; if (byte_rdy !== 1'b1) begin errs++; $display("FAIL lat_byte_rdy: got %b expected 1", byte_rdy); end
    @(posedge clk); #1;
    byte_vld = 1'b0;
    vectors++; if (data_in_vld !== 1'b0) begin errs++; $display("FAIL lat_early_vld: got %b expected 0", data_in_vld); end
    @(posedge clk); #1;
    vectors++;
    if (data_in_vld !== 1'b1 || data_in !== 5'd3 || ext_bits !== 6'd0) begin
      errs++; $display("FAIL lat_token: got vld=%b sym=%0d ext=%h expected vld=1 sym=3 ext=00", data_in_vld, data_in, ext_bits);
    end
  endtask

  task automatic test_directed();
    logic [7:0] seq [4][2];
    int         len [4];
    logic [4:0] s0 [4];
    logic [5:0] e0 [4];
    int         s1 [4];
    logic [7:0] q[$];
    logic [4:0] es[$], gs;
    logic [5:0] ex[$], ge;
    bit         to;
    seq = '{'{8'h23, 8'h00}, '{8'h33, 8'h00}, '{8'hFF, 8'h07}, '{8'hF0, 8'h05}};
    len = '{2, 1, 2, 2};
    s0  = '{5'd3, 5'd19, 5'd31, 5'd16};
    e0  = '{6'd0, 6'd1, 6'h3F, 6'd0};
    s1  = '{-1, -1, 0, 5};
    for (int t = 0; t < 4; t++) begin
      do_abort();
      q = {};
      for (int k = 0; k < len[t]; k++) q.push_back(seq[t][k]);
      model_tokens(q, es, ex);
      drive_stream(q, 100, 100, es.size(), to);
      vectors++; if (to) begin errs++; $display("FAIL dir%0d timeout: got %0d tokens expected %0d", t, obs_sym.size(), es.size()); end
      gs = 'x; ge = 'x;
      if (obs_sym.size() > 0) begin gs = obs_sym[0]; ge = obs_ext[0]; end
      vectors++;
      if (gs !== s0[t] || ge !== e0[t]) begin
        errs++; $display("FAIL dir%0d first_token: got sym=%0d ext=%h expected sym=%0d ext=%h", t, gs, ge, s0[t], e0[t]);
      end
      if (s1[t] >= 0) begin
        gs = 'x;
        if (obs_sym.size() > 1) gs = obs_sym[1];
        vectors++; if (gs !== 5'(s1[t])) begin errs++; $display("FAIL dir%0d second_token: got sym=%0d expected %0d", t, gs, s1[t]); end
      end
      if (t == 3) begin
        vectors++;
        if (obs_eob.size() == 0 || obs_eob[0] !== 1'b1) begin
          errs++; $display("FAIL dir%0d eob_done: not pulsed on EOB handshake (tokens %0d) expected 1", t, obs_eob.size());
        end
      end
      model_tokens(acc_q, es, ex);
      vectors++; if (obs_sym.size() != es.size()) begin errs++; $display("FAIL dir%0d token_count: got %0d expected %0d", t, obs_sym.size(), es.size()); end
      for (int i = 0; i < es.size() && i < obs_sym.size(); i++) begin
        vectors++;
        if (obs_sym[i] !== es[i] || obs_ext[i] !== ex[i] || obs_eob[i] !== (es[i] == 5'd16)) begin
          errs++; $display("FAIL dir%0d token%0d: got sym=%0d ext=%h eob=%b expected sym=%0d ext=%h eob=%b",
                           t, i, obs_sym[i], obs_ext[i], obs_eob[i], es[i], ex[i], es[i] == 5'd16);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [4:0] hs, es[$];
    logic [5:0] he, ex[$];
    int w;
    do_abort();
    byte_in = 8'h33; byte_vld = 1'b1; data_in_rdy = 1'b0;
    w = 0;
    while (!data_in_vld && w < 30) begin @(posedge clk); #1; w++; end
    vectors++; if (data_in_vld !== 1'b1) begin errs++; $display("FAIL bp_first_vld: got %b expected 1", data_in_vld); end
    hs = data_in; he = ext_bits;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      vectors++;
      if (data_in_vld !== 1'b1 || data_in !== hs || ext_bits !== he) begin
        errs++; $display("FAIL bp_hold%0d: got vld=%b sym=%0d ext=%h expected vld=1 sym=%0d ext=%h", c, data_in_vld, data_in, ext_bits, hs, he);
      end
    end
    vectors++; if (byte_rdy !== 1'b0) begin errs++; $display("FAIL bp_byte_rdy: got %b expected 0", byte_rdy); end
    vectors++; if (acc_q.size() != 3) begin errs++; $display("FAIL bp_bytes_taken: got %0d expected 3", acc_q.size()); end
    byte_vld = 1'b0; data_in_rdy = 1'b1;
    @(posedge clk); #1;
    vectors++; if (data_in_vld !== 1'b1) begin errs++; $display("FAIL bp_back_to_back: got vld=%b expected 1", data_in_vld); end
    repeat (20) @(posedge clk);
    #1 data_in_rdy = 1'b0;
    model_tokens(acc_q, es, ex);
    vectors++; if (obs_sym.size() != es.size()) begin errs++; $display("FAIL bp_token_count: got %0d expected %0d", obs_sym.size(), es.size()); end
    for (int i = 0; i < es.size() && i < obs_sym.size(); i++) begin
      vectors++;
      if (obs_sym[i] !== es[i] || obs_ext[i] !== ex[i]) begin
        errs++; $display("FAIL bp_token%0d: got sym=%0d ext=%h expected sym=%0d ext=%h", i, obs_sym[i], obs_ext[i], es[i], ex[i]);
      end
    end
  endtask

  task automatic test_full_boundary();
    logic [4:0] es[$];
    logic [5:0] ex[$];
    do_abort();
    byte_in = 8'h17; byte_vld = 1'b1; data_in_rdy = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    vectors++; if (acc_q.size() != 4) begin errs++; $display("FAIL full_bytes_taken: got %0d expected 4", acc_q.size()); end
    byte_vld = 1'b0; data_in_rdy = 1'b1;
    repeat (12) @(posedge clk);
    #1 data_in_rdy = 1'b0;
    model_tokens(acc_q, es, ex);
    vectors++; if (obs_sym.size() != es.size()) begin errs++; $display("FAIL full_token_count: got %0d expected %0d", obs_sym.size(), es.size()); end
    for (int i = 0; i < es.size() && i < obs_sym.size(); i++) begin
      vectors++;
      if (obs_sym[i] !== es[i] || obs_ext[i] !== ex[i]) begin
        errs++; $display("FAIL full_token%0d: got sym=%0d ext=%h expected sym=%0d ext=%h", i, obs_sym[i], obs_ext[i], es[i], ex[i]);
      end
    end
  endtask

  task automatic test_abort();
    logic [7:0] q[$];
    logic [4:0] es[$], gs;
    logic [5:0] ex[$], ge;
    bit to;
    int w;
    do_abort();
    byte_in = 8'h33; byte_vld = 1'b1; data_in_rdy = 1'b0;
    w = 0;
    while (!data_in_vld && w < 30) begin @(posedge clk); #1; w++; end
    vectors++; if (data_in_vld !== 1'b1) begin errs++; $display("FAIL abort_pre_vld: got %b expected 1", data_in_vld); end
    en = 1'b0;
    @(posedge clk); #1;
    vectors++; if (data_in_vld !== 1'b0) begin errs++; $display("FAIL abort_vld: got %b expected 0", data_in_vld); end
    vectors++; if (byte_rdy !== 1'b0)    begin errs++; $display("FAIL abort_byte_rdy: got %b expected 0", byte_rdy); end
    byte_vld = 1'b0;
    acc_q = {}; obs_sym = {}; obs_ext = {}; obs_eob = {};
    en = 1'b1;
    @(posedge clk); #1;
    q = {8'h23, 8'h00};
    model_tokens(q, es, ex);
    drive_stream(q, 100, 100, es.size(), to);
    gs = 'x; ge = 'x;
    if (obs_sym.size() > 0) begin gs = obs_sym[0]; ge = obs_ext[0]; end
    vectors++;
    if (to || gs !== 5'd3 || ge !== 6'd0) begin
      errs++; $display("FAIL abort_clean_restart: got sym=%0d ext=%h timeout=%b expected sym=3 ext=00 timeout=0", gs, ge, to);
    end
  endtask

  task automatic test_random();
    logic [7:0] q[$];
    logic [4:0] es[$];
    logic [5:0] ex[$];
    bit to;
    for (int r = 0; r < 4; r++) begin
      do_abort();
      q = {};
      for (int k = 0; k < 24; k++) q.push_back(($urandom_range(5) == 0) ? 8'hF0 : 8'($urandom));
      model_tokens(q, es, ex);
      drive_stream(q, $urandom_range(40, 100), $urandom_range(30, 100), es.size(), to);
      vectors++; if (to) begin errs++; $display("FAIL rnd%0d timeout: got %0d tokens expected %0d", r, obs_sym.size(), es.size()); end
      vectors++; if (stray_eob != 0) begin errs++; $display("FAIL rnd%0d stray_eob: got %0d expected 0", r, stray_eob); end
      model_tokens(acc_q, es, ex);
      vectors++; if (obs_sym.size() != es.size()) begin errs++; $display("FAIL rnd%0d token_count: got %0d expected %0d", r, obs_sym.size(), es.size()); end
      for (int i = 0; i < es.size() && i < obs_sym.size(); i++) begin
        vectors++;
        if (obs_sym[i] !== es[i] || obs_ext[i] !== ex[i] || obs_eob[i] !== (es[i] == 5'd16)) begin
          errs++; $display("FAIL rnd%0d token%0d: got sym=%0d ext=%h eob=%b expected sym=%0d ext=%h eob=%b",
                           r, i, obs_sym[i], obs_ext[i], obs_eob[i], es[i], ex[i], es[i] == 5'd16);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    int w;
    do_abort();
    byte_in = 8'h33; byte_vld = 1'b1; data_in_rdy = 1'b0;
    w = 0;
    while (!data_in_vld && w < 30) begin @(posedge clk); #1; w++; end
    vectors++; if (data_in_vld !== 1'b1) begin errs++; $display("FAIL arst_pre_vld: got %b expected 1", data_in_vld); end
    #2 rst_n = 1'b0;
    #1;
    vectors++; if (data_in_vld !== 1'b0) begin errs++; $display("FAIL arst_vld: got %b expected 0", data_in_vld); end
    vectors++; if (data_in !== 5'd0)     begin errs++; $display("FAIL arst_data_in: got %0d expected 0", data_in); end
    vectors++; if (ext_bits !== 6'd0)    begin errs++; $display("FAIL arst_ext_bits: got %h expected 0", ext_bits); end
    vectors++; if (byte_rdy !== 1'b0)    begin errs++; $display("FAIL arst_byte_rdy: got %b expected 0", byte_rdy); end
    byte_vld = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_latency();
    test_directed();
    test_backpressure();
    test_full_boundary();
    test_abort();
    test_random();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule

// File: doc/lz_sym_unpacker.md
# lz_sym_unpacker

- Bitstream front end of the inflate core.
- Accepts a byte stream and unpacks it LSB-first into 5-bit LZ symbols, each with its symbol-dependent extra bits.
- Presents each token on a valid/ready interface that connects directly to `lz_extractor` (`data_in`, `ext_bits`, `data_in_vld`, `data_in_rdy`).
- Handles end-of-block byte realignment and holds tokens under downstream backpressure.

## Interface
Parameters:
- `BUF_W`, 24: bit-buffer width. Minimum is 24: max token 11 bits plus one accepted byte when count ≤ 16.
- `CNT_W`, 5: bit-count width, range 0..24.

Ports (reset `rst_n`, asynchronous, active-low; clock `clk`):
- `clk`  in  1  clock
- `rst_n`  in  1  async active-low reset
- `en`  in  1  block enable; low = synchronous abort/idle
- `byte_vld`  in  1  input byte valid
- `byte_in`  in  8  input byte; bit0 is the first stream bit
- `byte_rdy`  out  1  input byte ready
- `data_in_vld`  out  1  token valid to `lz_extractor`
- `data_in`  out  5  symbol
- `ext_bits`  out  6  extra bits, zero-extended; first stream bit in bit0
- `data_in_rdy`  in  1  token ready from `lz_extractor`
- `eob_done`  out  1  one-cycle pulse when the EOB token handshakes

## Operation
- Symbol map (`lz_pkg`):
  - 0..15: literal nibble, 0 extra bits.
  - 16: EOB, 0 extra bits.
  - 17..24: length codes, extra bits = (sym-17)>>1, giving 0,0,1,1,2,2,3,3.
  - 25..31: distance codes, extra bits = sym-25, giving 0..6.
- Bit buffer `bbuf[23:0]` with count `cnt`; bit0 is the oldest bit.
- Token need: `need = 5 + ext_len(bbuf[4:0])`, valid only when `cnt ≥ 5`.
- Byte append: `byte_rdy = en && state!=IDLE && cnt ≤ 16`. On handshake, the byte is written at offset `cnt - consumed`.
- Extract condition: state==RUN, `cnt ≥ 5`, `cnt ≥ need`, and the output slot is empty or handshaking this cycle.
- Extract action:
  - Load `data_in = bbuf[4:0]` and `ext_bits = bbuf[need-1:5]` zero-extended.
  - Shift the buffer right by `need`.
- Append and consume in the same cycle: `cnt_next = cnt - consumed + 8`.
- EOB extraction additionally discards `(cnt - 5) mod 8` bits (the rest of the current byte), so the next token starts byte-aligned.
- FSM:
  - IDLE: all state cleared; go to RUN when `en` = 1.
  - RUN: append/extract; go to EOB_WAIT on extracting symbol 16.
  - EOB_WAIT: no extraction, appends allowed. On the EOB handshake, pulse `eob_done` and go to RUN.
  - Any state with `en` = 0: go to IDLE next cycle, clearing the buffer, `cnt` and `data_in_vld`. A pending token is dropped; this is the defined abort.

## Timing
- Reset values: `byte_rdy` = 0, `data_in_vld` = 0, `data_in` = 0, `ext_bits` = 0, `eob_done` = 0. State is IDLE with `cnt` = 0.
- Output token is registered. `data_in`/`ext_bits` stay stable while `data_in_vld && !data_in_rdy`.
- Latency:
  - Byte accepted at edge N; `cnt` updated after N.
  - The token is extracted at edge N+1, so `data_in_vld` is high in the cycle after edge N+1.
- Throughput: one token per cycle when the buffer is sufficient. Back-to-back handshakes are allowed.
- `byte_rdy` is a function of registers and `en` only. It must have no combinational path from `data_in_rdy`.
- Boundaries:
  - `cnt` = 16 accepts a byte (giving 24); `cnt` = 17 does not.
  - A token needing 11 bits with `cnt` in 9..10 must still accept a byte. There must be no deadlock.
- An async reset mid-token forces all outputs to reset values immediately.

## Structure
- `lz_pkg`:
  - Symbol constants `SYM_EOB=16`, `SYM_LEN_BASE=17`, `SYM_DIST_BASE=25`.
  - Function `ext_len(logic [4:0])` returning `[2:0]`.
  - State enum `{IDLE, RUN, EOB_WAIT}`.
- Shared with `lz_extractor`.
- No sub-modules; the single module is expected at about 150–250 lines of RTL.

## Test plan
- Bytes 0x23, 0x00, `data_in_rdy` = 1 → token `data_in`=3, `ext_bits`=0. The leftover zero bits then yield literal tokens 0 as `cnt` allows.
- Byte 0x33 → `data_in`=19, `ext_bits`=1 (6 bits consumed, `cnt`=2).
- Bytes 0xFF, 0x07 → `data_in`=31, `ext_bits`=0x3F (11 bits consumed, `cnt`=5). The following token is symbol 0.
- Bytes 0xF0, 0x05 → EOB token (16,0), with bits 5..7 of 0xF0 discarded; `eob_done` pulses on the handshake. The next token is literal 5.
- Hold `data_in_rdy`=0 for 6 cycles while streaming 0x33 bytes → token stable and `byte_rdy` drops once `cnt` > 16. On release, tokens resume at one per cycle with no loss.
- Drop `en` while `data_in_vld`=1 → next cycle `data_in_vld`=0, `cnt`=0. Separately, assert `rst_n`=0 mid-stream → outputs immediately at reset values.
